reg_file_sb: RTL and testbench



---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_scoreboard.sv | 66 ++++++
 rtl/reg_file_sb.sv | 104 ++++++++++
 tb/tb_reg_file_sb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the scoreboarded register file.
//   DEFAULT_XLEN  - default register data width
//   ZERO_REG      - index of the hard-wired zero register (x0)
//   addr_width()  - address width for a given register count
//   count_width() - width needed to count 0..NREGS pending registers
//   RF_SLICE      - selects port slice idx of width w from a packed port bus
package rf_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int ZERO_REG     = '0;

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

  function automatic int count_width(input int nregs);
    return $clog2(nregs + 1);
  endfunction

endpackage

`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one pending bit per register plus a running count of pending
// registers, used by the decode-stage hazard logic.
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   iss_en, iss_addr  - issue strobe; marks iss_addr pending
//   we, wr_addr       - write-back; clears wr_addr pending
//   pending           - current pending vector (bit 0 always 0)
//   busy_cnt          - number of pending registers
//   all_idle          - high when nothing is pending
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iss_en,
  input  logic [addr_width(NREGS)-1:0]  iss_addr,
  input  logic                          we,
  input  logic [addr_width(NREGS)-1:0]  wr_addr,
  output logic [NREGS-1:0]              pending,
  output logic [count_width(NREGS)-1:0] busy_cnt,
  output logic                          all_idle
);

  localparam int AW = addr_width(NREGS);
  localparam int CW = count_width(NREGS);
  localparam logic [AW-1:0] X0 = AW'(ZERO_REG);

  logic [NREGS-1:0] pending_q, pending_d, set_vec, clr_vec;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             set_ok, clr_ok, inc, dec;

  // Set is applied after clear so a new producer supersedes a same-cycle
  // write-back to the same register. The count moves by at most one per
  // cycle: +1 only when a clear bit becomes set, -1 only when a set bit is
  // cleared and not re-set in the same cycle.
  always_comb begin
    set_ok  = iss_en && (iss_addr != X0);
    clr_ok  = we && (wr_addr != X0);
    set_vec = '0;
    clr_vec = '0;
    if (set_ok) set_vec[iss_addr] = 1'b1;
    if (clr_ok) clr_vec[wr_addr] = 1'b1;
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
    inc   = set_ok && !pending_q[iss_addr];
    dec   = clr_ok && pending_q[wr_addr] && !(set_ok && (iss_addr == wr_addr));
    cnt_d = cnt_q + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending  = pending_q;
  assign busy_cnt = cnt_q;
  assign all_idle = (cnt_q == '0);

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with NRD registered read ports,
// optional write-to-read bypass, a pending scoreboard and a registered debug
// read port.
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   rd_addr, rd_data  - packed read ports (port i at [i*AW +: AW] / [i*XLEN +: XLEN])
//   rd_busy           - registered pending flag of each addressed register
//   we, wr_addr, wr_data - write-back port (x0 writes ignored)
//   iss_en, iss_addr  - issue strobe marking a destination pending
//   busy_cnt, all_idle - pending register count and its zero flag
//   dbg_addr, dbg_data - registered debug read, never bypassed
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NRD*addr_width(NREGS)-1:0]  rd_addr,
  output logic [NRD*XLEN-1:0]               rd_data,
  output logic [NRD-1:0]                    rd_busy,
  input  logic                              we,
  input  logic [addr_width(NREGS)-1:0]      wr_addr,
  input  logic [XLEN-1:0]                   wr_data,
  input  logic                              iss_en,
  input  logic [addr_width(NREGS)-1:0]      iss_addr,
  output logic [count_width(NREGS)-1:0]     busy_cnt,
  output logic                              all_idle,
  input  logic [addr_width(NREGS)-1:0]      dbg_addr,
  output logic [XLEN-1:0]                   dbg_data
);

  localparam int AW = addr_width(NREGS);
  localparam logic [AW-1:0] X0 = AW'(ZERO_REG);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    pending;
  logic [NRD*XLEN-1:0] rd_data_d, rd_data_q;
  logic [NRD-1:0]      rd_busy_d, rd_busy_q;
  logic [XLEN-1:0]     dbg_d, dbg_q;
  logic [AW-1:0]       ra [NRD];
  logic                hit [NRD];
  logic                wr_ok;

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .we       (we),
    .wr_addr  (wr_addr),
    .pending  (pending),
    .busy_cnt (busy_cnt),
    .all_idle (all_idle)
  );

  // Read muxing. A same-cycle write-back is forwarded only when bypass is
  // enabled; the busy flag drops on a bypassed hit because the reader already
  // receives the produced value. A same-cycle issue is deliberately ignored
  // since the reader is older than the issuing instruction.
  always_comb begin
    wr_ok     = we && (wr_addr != X0);
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int i = 0; i < NRD; i++) begin
      ra[i]  = `RF_SLICE(rd_addr, i, AW);
      hit[i] = (BYPASS != 0) && we && (wr_addr == ra[i]);
      if (ra[i] == X0)
        `RF_SLICE(rd_data_d, i, XLEN) = '0;
      else if (hit[i] && wr_ok)
        `RF_SLICE(rd_data_d, i, XLEN) = wr_data;
      else
        `RF_SLICE(rd_data_d, i, XLEN) = regs[ra[i]];
      rd_busy_d[i] = pending[ra[i]] & ~hit[i];
    end
    dbg_d = (dbg_addr == X0) ? '0 : regs[dbg_addr];
  end

  // Array and output registers; reset wipes everything and wins over a
  // same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
      dbg_q     <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
      dbg_q     <= dbg_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_busy  = rd_busy_q;
  assign dbg_data = dbg_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: self-checking bench for reg_file_sb. Two instances share all
// inputs, one with bypass and one without, and are compared against a
// behavioural model of registers and pending flags.
module tb_reg_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
  localparam int CW    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic                we;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [AW-1:0]       dbg_addr;

  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic [CW-1:0]       busy_cnt_b, busy_cnt_n;
  logic                all_idle_b, all_idle_n;
  logic [XLEN-1:0]     dbg_data_b, dbg_data_n;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt_b), .all_idle(all_idle_b), .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
  );

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt_n), .all_idle(all_idle_n), .dbg_addr(dbg_addr), .dbg_data(dbg_data_n)
  );

  // Reference model state and the expectations for the upcoming edge.
  logic [XLEN-1:0] ref_regs [NREGS];
  bit              ref_pend [NREGS];
  logic [XLEN-1:0] exp_rd_b [NRD];
  logic [XLEN-1:0] exp_rd_n [NRD];
  logic            exp_bz_b [NRD];
  logic            exp_bz_n [NRD];
  logic [XLEN-1:0] exp_dbg;
  int              exp_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic set_port(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    we       = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
  endtask

  // Predict outputs from the model state before the edge, clock once, then
  // apply the edge's effect to the model.
  task automatic cycle();
    int a;
    for (int p = 0; p < NRD; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      if (!rst || a == 0) begin
        exp_rd_b[p] = '0;
        exp_rd_n[p] = '0;
        exp_bz_b[p] = 1'b0;
        exp_bz_n[p] = 1'b0;
      end else begin
        exp_rd_n[p] = ref_regs[a];
        exp_rd_b[p] = (we && int'(wr_addr) == a) ? wr_data : ref_regs[a];
        exp_bz_n[p] = ref_pend[a];
        exp_bz_b[p] = ref_pend[a] && !(we && int'(wr_addr) == a);
      end
    end
    exp_dbg = (!rst || dbg_addr == 0) ? '0 : ref_regs[dbg_addr];
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) begin
        ref_regs[k] = '0;
        ref_pend[k] = 1'b0;
      end
    end else begin
      if (we && wr_addr != 0) begin
        ref_regs[wr_addr] = wr_data;
        ref_pend[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) ref_pend[iss_addr] = 1'b1;
    end
    exp_cnt = 0;
    for (int k = 0; k < NREGS; k++) exp_cnt += int'(ref_pend[k]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD;
    iss_en = 1'b1; iss_addr = 5'd3;
    rd_addr = '0; dbg_addr = 5'd5;
    cycle();
    n_checks++;
    if (busy_cnt_b !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", busy_cnt_b); end
    n_checks++;
    if (all_idle_b !== 1'b1 || all_idle_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_idle: got %b/%b want 1", all_idle_b, all_idle_n); end
    n_checks++;
    if (rd_data_b !== '0 || dbg_data_b !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %h/%h want 0", rd_data_b, dbg_data_b); end

    rst = 1'b1;
    idle();
    set_port(0, 5); set_port(1, 3); dbg_addr = 5'd5;
    cycle();
    n_checks++;
    if (rd_data_b !== '0 || dbg_data_b !== '0) begin n_fail++; $display("[TB] FAIL reset_write_dropped: got %h/%h want 0", rd_data_b, dbg_data_b); end
    n_checks++;
    if (rd_busy_b !== 2'b00 || busy_cnt_b !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_issue_dropped: busy %b cnt %0d want 00/0", rd_busy_b, busy_cnt_b); end

    // Write to x0 while reading x0 in the same cycle, then read it again.
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    set_port(0, 0); set_port(1, 0); dbg_addr = 5'd0;
    cycle();
    n_checks++;
    if (rd_data_b !== '0) begin n_fail++; $display("[TB] FAIL x0_bypass: got %h want 0", rd_data_b); end
    idle();
    cycle();
    n_checks++;
    if (rd_data_b !== '0 || rd_data_n !== '0 || dbg_data_b !== '0) begin n_fail++; $display("[TB] FAIL x0_read: got %h/%h/%h want 0", rd_data_b, rd_data_n, dbg_data_b); end
  endtask

  task automatic test_latency();
    idle();
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_0001;
    cycle();
    wr_addr = 5'd7; wr_data = 32'h0000_FFFF;
    cycle();
    idle();
    set_port(0, 3); set_port(1, 7); dbg_addr = 5'd7;
    cycle();
    n_checks++;
    if (rd_data_b !== {32'h0000_FFFF, 32'hA5A5_0001}) begin n_fail++; $display("[TB] FAIL two_ports_b: got %h want 0000ffffa5a50001", rd_data_b); end
    n_checks++;
    if (rd_data_n !== {32'h0000_FFFF, 32'hA5A5_0001}) begin n_fail++; $display("[TB] FAIL two_ports_n: got %h want 0000ffffa5a50001", rd_data_n); end
    set_port(0, 7); set_port(1, 7); dbg_addr = 5'd3;
    cycle();
    n_checks++;
    if (rd_data_b !== {32'h0000_FFFF, 32'h0000_FFFF}) begin n_fail++; $display("[TB] FAIL same_addr: got %h want 0000ffff0000ffff", rd_data_b); end
    n_checks++;
    if (dbg_data_b !== 32'hA5A5_0001) begin n_fail++; $display("[TB] FAIL dbg_read: got %h want a5a50001", dbg_data_b); end
  endtask

  task automatic test_bypass();
    idle();
    iss_en = 1'b1; iss_addr = 5'd9;
    cycle();
    idle();
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
    cycle();
    idle();
    iss_en = 1'b1; iss_addr = 5'd9;
    cycle();
    idle();
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    set_port(0, 9); set_port(1, 0); dbg_addr = 5'd9;
    cycle();
    n_checks++;
    if (rd_data_b[31:0] !== 32'h55 || rd_busy_b[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_on: data %h busy %b want 55/0", rd_data_b[31:0], rd_busy_b[0]); end
    n_checks++;
    if (rd_data_n[31:0] !== 32'h11 || rd_busy_n[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_off: data %h busy %b want 11/1", rd_data_n[31:0], rd_busy_n[0]); end
    n_checks++;
    if (dbg_data_b !== 32'h11) begin n_fail++; $display("[TB] FAIL dbg_no_bypass: got %h want 11", dbg_data_b); end
    idle();
    cycle();
    n_checks++;
    if (rd_data_n[31:0] !== 32'h55 || rd_busy_n[0] !== 1'b0 || busy_cnt_n !== 6'd0) begin n_fail++; $display("[TB] FAIL after_wb: data %h busy %b cnt %0d want 55/0/0", rd_data_n[31:0], rd_busy_n[0], busy_cnt_n); end
  endtask

  task automatic test_scoreboard();
    logic [AW-1:0] seq_addr [3];
    int            seq_cnt [3];
    seq_addr[0] = 5'd4; seq_addr[1] = 5'd5; seq_addr[2] = 5'd4;
    seq_cnt[0] = 1; seq_cnt[1] = 2; seq_cnt[2] = 2;
    rst = 1'b0; idle(); rd_addr = '0; dbg_addr = '0;
    cycle();
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      iss_en = 1'b1; iss_addr = seq_addr[s];
      cycle();
      n_checks++;
      if (busy_cnt_b !== CW'(seq_cnt[s]) || all_idle_b !== 1'b0) begin n_fail++; $display("[TB] FAIL issue_%0d: cnt %0d idle %b want %0d/0", s, busy_cnt_b, all_idle_b, seq_cnt[s]); end
    end
    idle();
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    cycle();
    n_checks++;
    if (busy_cnt_b !== 6'd1) begin n_fail++; $display("[TB] FAIL wb_x4: cnt %0d want 1", busy_cnt_b); end
    wr_addr = 5'd5; wr_data = 32'h55;
    cycle();
    n_checks++;
    if (busy_cnt_b !== 6'd0 || all_idle_b !== 1'b1) begin n_fail++; $display("[TB] FAIL wb_x5: cnt %0d idle %b want 0/1", busy_cnt_b, all_idle_b); end
    wr_addr = 5'd5; wr_data = 32'h56;
    cycle();
    n_checks++;
    if (busy_cnt_b !== 6'd0) begin n_fail++; $display("[TB] FAIL wb_not_pending: cnt %0d want 0", busy_cnt_b); end
    idle();
    iss_en = 1'b1; iss_addr = 5'd0;
    cycle();
    n_checks++;
    if (busy_cnt_b !== 6'd0 || busy_cnt_n !== 6'd0 || all_idle_b !== 1'b1) begin n_fail++; $display("[TB] FAIL issue_x0: cnt %0d/%0d idle %b want 0/0/1", busy_cnt_b, busy_cnt_n, all_idle_b); end
  endtask

  task automatic test_set_clear();
    idle();
    iss_en = 1'b1; iss_addr = 5'd6;
    cycle();
    n_checks++;
    if (busy_cnt_b !== 6'd1) begin n_fail++; $display("[TB] FAIL x6_issue: cnt %0d want 1", busy_cnt_b); end
    we = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFE_0006;
    cycle();
    n_checks++;
    if (busy_cnt_b !== 6'd1) begin n_fail++; $display("[TB] FAIL set_clear_cnt: cnt %0d want 1", busy_cnt_b); end
    idle();
    set_port(0, 6); set_port(1, 6); dbg_addr = 5'd6;
    cycle();
    n_checks++;
    if (rd_busy_b !== 2'b11 || rd_data_b[31:0] !== 32'hCAFE_0006 || dbg_data_b !== 32'hCAFE_0006) begin n_fail++; $display("[TB] FAIL set_clear_state: busy %b data %h dbg %h want 11/cafe0006/cafe0006", rd_busy_b, rd_data_b[31:0], dbg_data_b); end
  endtask

  task automatic test_mid_reset();
    idle();
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'h77;
    cycle();
    idle();
    for (int r = 1; r <= 3; r++) begin
      iss_en = 1'b1; iss_addr = AW'(r);
      cycle();
    end
    n_checks++;
    if (busy_cnt_b !== 6'd4) begin n_fail++; $display("[TB] FAIL pre_reset_cnt: cnt %0d want 4", busy_cnt_b); end
    rst = 1'b0;
    we = 1'b1; wr_addr = 5'd13; wr_data = 32'h99;
    iss_en = 1'b1; iss_addr = 5'd14;
    set_port(0, 12); set_port(1, 1); dbg_addr = 5'd12;
    cycle();
    n_checks++;
    if (busy_cnt_b !== 6'd0 || all_idle_b !== 1'b1 || rd_busy_b !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_reset_sb: cnt %0d idle %b busy %b want 0/1/00", busy_cnt_b, all_idle_b, rd_busy_b); end
    rst = 1'b1;
    idle();
    dbg_addr = 5'd13;
    cycle();
    n_checks++;
    if (rd_data_b !== '0 || rd_busy_b !== 2'b00 || dbg_data_b !== '0) begin n_fail++; $display("[TB] FAIL mid_reset_data: data %h busy %b dbg %h want 0", rd_data_b, rd_busy_b, dbg_data_b); end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 59) != 0);
      we       = 1'($urandom_range(0, 1));
      wr_addr  = rand_addr();
      wr_data  = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = rand_addr();
      dbg_addr = rand_addr();
      for (int p = 0; p < NRD; p++) set_port(p, int'(rand_addr()));
      cycle();
      for (int p = 0; p < NRD; p++) begin
        n_checks++;
        if (rd_data_b[p*XLEN +: XLEN] !== exp_rd_b[p] || rd_busy_b[p] !== exp_bz_b[p]) begin
          n_fail++;
          $display("[TB] FAIL rand_b_port%0d cyc %0d: data %h busy %b want %h/%b", p, c, rd_data_b[p*XLEN +: XLEN], rd_busy_b[p], exp_rd_b[p], exp_bz_b[p]);
        end
        n_checks++;
        if (rd_data_n[p*XLEN +: XLEN] !== exp_rd_n[p] || rd_busy_n[p] !== exp_bz_n[p]) begin
          n_fail++;
          $display("[TB] FAIL rand_n_port%0d cyc %0d: data %h busy %b want %h/%b", p, c, rd_data_n[p*XLEN +: XLEN], rd_busy_n[p], exp_rd_n[p], exp_bz_n[p]);
        end
      end
      n_checks++;
      if (busy_cnt_b !== CW'(exp_cnt) || busy_cnt_n !== CW'(exp_cnt) || all_idle_b !== (exp_cnt == 0)) begin
        n_fail++;
        $display("[TB] FAIL rand_cnt cyc %0d: cnt %0d/%0d idle %b want %0d", c, busy_cnt_b, busy_cnt_n, all_idle_b, exp_cnt);
      end
      n_checks++;
      if (dbg_data_b !== exp_dbg || dbg_data_n !== exp_dbg) begin
        n_fail++;
        $display("[TB] FAIL rand_dbg cyc %0d: got %h/%h want %h", c, dbg_data_b, dbg_data_n, exp_dbg);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NREGS; k++) begin
      ref_regs[k] = '0;
      ref_pend[k] = 1'b0;
    end
    exp_cnt = 0;
    rst = 1'b0;
    rd_addr = '0;
    dbg_addr = '0;
    idle();
    $display("[TB] starting reg_file_sb bench");
    test_reset();
    test_latency();
    test_bypass();
    test_scoreboard();
    test_set_clear();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
